bcd: RTL and testbench



---
 rtl/bcd.sv | 60 ++++++
 tb/tb_bcd.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd.sv
// Registered packed-BCD adder with ripple decimal carry.
// Flags any non-BCD operand digit alongside the registered sum.
module bcd #(
    parameter int DIGITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    logic [4*DIGITS-1:0] sum_d;
    logic [DIGITS:0]     c;
    logic                err_d;
    logic [4:0]          t;
    logic [3:0]          ad;
    logic [3:0]          bd;

    // Out-of-range digits still go through the +6 correction unchanged.
    always_comb begin
        c     = '0;
        c[0]  = cin;
        sum_d = '0;
        err_d = 1'b0;
        t     = '0;
        ad    = '0;
        bd    = '0;
        for (int d = 0; d < DIGITS; d++) begin
            ad = a[4*d +: 4];
            bd = b[4*d +: 4];
            t  = {1'b0, ad} + {1'b0, bd} + {4'b0, c[d]};
            if (t > 5'd9) begin
                sum_d[4*d +: 4] = t[3:0] + 4'd6;
                c[d+1]          = 1'b1;
            end else begin
                sum_d[4*d +: 4] = t[3:0];
                c[d+1]          = 1'b0;
            end
            if (ad > 4'd9 || bd > 4'd9)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            err  <= 1'b0;
        end else begin
            sum  <= sum_d;
            cout <= c[DIGITS];
            err  <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd.sv
// Scoreboard bench for bcd: one- and two-digit instances.
// Expected results are queued at drive time and popped after the edge.
module tb_bcd;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a1 = '0;
    logic [3:0] b1 = '0;
    logic       c1 = 1'b0;
    logic [3:0] s1;
    logic       co1;
    logic       e1;
    logic [7:0] a2 = '0;
    logic [7:0] b2 = '0;
    logic       c2 = 1'b0;
    logic [7:0] s2;
    logic       co2;
    logic       e2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bcd #(.DIGITS(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .err(e1)
    );

    bcd #(.DIGITS(2)) u2 (
        .clk(clk), .rst(rst), .a(a2), .b(b2), .cin(c2),
        .sum(s2), .cout(co2), .err(e2)
    );

    function automatic exp_t ref1(input int a, input int b, input int ci);
        exp_t e;
        int   v;
        v      = a + b + ci;
        e.sum  = 8'(v % 10);
        e.cout = (v >= 10);
        e.err  = 1'b0;
        return e;
    endfunction

    function automatic exp_t ref2(input logic [7:0] a, input logic [7:0] b,
                                  input int ci);
        exp_t e;
        int   v;
        v = int'(a[7:4]) * 10 + int'(a[3:0])
          + int'(b[7:4]) * 10 + int'(b[3:0]) + ci;
        e.cout = (v >= 100);
        v      = v % 100;
        e.sum  = {4'(v / 10), 4'(v % 10)};
        e.err  = 1'b0;
        return e;
    endfunction

    task automatic drive1(input logic r, input logic [3:0] a,
                          input logic [3:0] b, input logic ci, input exp_t e);
        @(negedge clk);
        rst = r;
        a1  = a;
        b1  = b;
        c1  = ci;
        q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input exp_t e);
        @(negedge clk);
        rst = 1'b0;
        a2  = a;
        b2  = b;
        c2  = ci;
        q2.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t z;
        z = '{sum: 8'h00, cout: 1'b0, err: 1'b0};
        @(negedge clk);
        rst = 1'b1;
        a1  = 4'd9; b1 = 4'd12; c1 = 1'b1;
        a2  = 8'h99; b2 = 8'hff; c2 = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({co1, e1, s1} !== {z.cout, z.err, z.sum[3:0]}) begin
            n_fail++;
            $display("FAIL reset1 got c=%b e=%b s=%h want 0/0/0", co1, e1, s1);
        end
        n_chk++;
        if ({co2, e2, s2} !== {z.cout, z.err, z.sum}) begin
            n_fail++;
            $display("FAIL reset2 got c=%b e=%b s=%h want 0/0/00", co2, e2, s2);
        end
    endtask

    task automatic test_basic;
        logic [3:0] ta[4] = '{4'd5, 4'd5, 4'd9, 4'd0};
        logic [3:0] tb[4] = '{4'd4, 4'd5, 4'd9, 4'd0};
        logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_t       e;
        for (int i = 0; i < 4; i++) begin
            drive1(1'b0, ta[i], tb[i], tc[i],
                   ref1(int'(ta[i]), int'(tb[i]), int'(tc[i])));
            e = q1.pop_front();
            n_chk++;
            if ({co1, e1, s1} !== {e.cout, e.err, e.sum[3:0]}) begin
                n_fail++;
                $display("FAIL basic%0d got c=%b e=%b s=%h want c=%b e=%b s=%h",
                         i, co1, e1, s1, e.cout, e.err, e.sum[3:0]);
            end
        end
    endtask

    task automatic test_sweep;
        exp_t e;
        for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 10; a++)
                for (int b = 0; b < 10; b++) begin
                    drive1(1'b0, 4'(a), 4'(b), 1'(ci), ref1(a, b, ci));
                    e = q1.pop_front();
                    n_chk++;
                    if ({co1, e1, s1} !== {e.cout, e.err, e.sum[3:0]}) begin
                        n_fail++;
                        $display("FAIL sweep %0d+%0d+%0d got c=%b e=%b s=%h want c=%b s=%h",
                                 a, b, ci, co1, e1, s1, e.cout, e.sum[3:0]);
                    end
                end
    endtask

    task automatic test_invalid;
        exp_t e;
        drive1(1'b0, 4'd12, 4'd3, 1'b0,
               '{sum: 8'h05, cout: 1'b1, err: 1'b1});
        e = q1.pop_front();
        n_chk++;
        if ({co1, e1, s1} !== {e.cout, e.err, e.sum[3:0]}) begin
            n_fail++;
            $display("FAIL invalid got c=%b e=%b s=%h want 1/1/5", co1, e1, s1);
        end
        drive1(1'b0, 4'd2, 4'd3, 1'b0, ref1(2, 3, 0));
        e = q1.pop_front();
        n_chk++;
        if ({co1, e1, s1} !== {e.cout, e.err, e.sum[3:0]}) begin
            n_fail++;
            $display("FAIL invalid_clear got c=%b e=%b s=%h want 0/0/5", co1, e1, s1);
        end
    endtask

    task automatic test_ripple;
        logic [7:0] ta[4] = '{8'h99, 8'h45, 8'h50, 8'h99};
        logic [7:0] tb[4] = '{8'h01, 8'h38, 8'h49, 8'h99};
        logic       tc[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_t       e;
        for (int i = 0; i < 4; i++) begin
            drive2(ta[i], tb[i], tc[i],
                   ref2(ta[i], tb[i], int'(tc[i])));
            e = q2.pop_front();
            n_chk++;
            if ({co2, e2, s2} !== {e.cout, e.err, e.sum}) begin
                n_fail++;
                $display("FAIL ripple%0d got c=%b e=%b s=%h want c=%b e=%b s=%h",
                         i, co2, e2, s2, e.cout, e.err, e.sum);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic r[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        exp_t z;
        z = '{sum: 8'h00, cout: 1'b0, err: 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive1(r[i], 4'd7, 4'd8, 1'b0, r[i] ? z : ref1(7, 8, 0));
            e = q1.pop_front();
            n_chk++;
            if ({co1, e1, s1} !== {e.cout, e.err, e.sum[3:0]}) begin
                n_fail++;
                $display("FAIL midreset%0d got c=%b e=%b s=%h want c=%b e=%b s=%h",
                         i, co1, e1, s1, e.cout, e.err, e.sum[3:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_invalid();
        test_ripple();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
